// File: rtl/decodificador_pkg.sv
// rtl/decodificador_pkg.sv - shared states, ASCII limits and BCD helpers for the weight command decoder
package decodificador_pkg;

    localparam int         LARGURA_PESO = 7;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;

    typedef enum logic [3:0] {
        ESPERA_CMD = 4'd0,
        MIN_D      = 4'd1,
        MIN_U      = 4'd2,
        MAX_D      = 4'd3,
        MAX_U      = 4'd4,
        ATUAL_D    = 4'd5,
        ATUAL_U    = 4'd6,
        CONFIRMA   = 4'd7
    } estado_t;

    function automatic logic eh_digito(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // 9*10+9 = 99 fits in 7 bits, so no widening is needed
    function automatic logic [LARGURA_PESO-1:0] bcd_para_bin(input logic [3:0] dez,
                                                             input logic [3:0] uni);
        return ({3'b000, dez} * 7'd10) + {3'b000, uni};
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - idle-cycle counter raising a one-cycle overflow pulse at LIMITE
module contador_timeout #(
    parameter int LIMITE = 86800
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic estouro
);

    localparam int W = $clog2(LIMITE + 1);

    logic [W-1:0] r_cont;

    // A clear in the same cycle suppresses the pulse, so a late byte beats the timeout
    assign estouro = enable && !clear && (r_cont == W'(LIMITE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont <= '0;
        end else if (clear || estouro) begin
            r_cont <= '0;
        end else if (enable) begin
            r_cont <= r_cont + W'(1);
        end
    end

endmodule

// File: rtl/decodificador_comando_peso.sv
// rtl/decodificador_comando_peso.sv - parses CMD + six ASCII digits into min/max/current weights; DECOD_PESO_CHECA_FAIXA_EN rejects min > max
module decodificador_comando_peso
    import decodificador_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE       = 8'h30,
    parameter int         TIMEOUT_CICLOS = 86800
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              dado_recebido,
    input  logic                    pronto_rx,
    output logic [LARGURA_PESO-1:0] peso_min,
    output logic [LARGURA_PESO-1:0] peso_max,
    output logic [LARGURA_PESO-1:0] peso_atual,
    output logic                    novo_dado,
    output logic                    alarme,
    output logic                    erro,
    output logic [3:0]              db_estado
);

    estado_t                 r_estado;
    logic [3:0]              r_min_d, r_min_u, r_max_d, r_max_u, r_atual_d, r_atual_u;
    logic [LARGURA_PESO-1:0] r_min, r_max, r_atual;
    logic                    r_novo, r_erro, r_alarme;
    logic [LARGURA_PESO-1:0] w_min_sh, w_max_sh, w_atual_sh;
    logic                    w_estouro;
    logic                    w_ocioso;

    assign w_ocioso   = (r_estado == ESPERA_CMD);
    assign w_min_sh   = bcd_para_bin(r_min_d, r_min_u);
    assign w_max_sh   = bcd_para_bin(r_max_d, r_max_u);
    assign w_atual_sh = bcd_para_bin(r_atual_d, r_atual_u);

    contador_timeout #(.LIMITE(TIMEOUT_CICLOS)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (pronto_rx || w_ocioso),
        .enable  (!w_ocioso),
        .estouro (w_estouro)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= ESPERA_CMD;
            r_min_d   <= '0;
            r_min_u   <= '0;
            r_max_d   <= '0;
            r_max_u   <= '0;
            r_atual_d <= '0;
            r_atual_u <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_atual   <= '0;
            r_novo    <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            r_novo <= 1'b0;
            r_erro <= 1'b0;
            case (r_estado)
                ESPERA_CMD: begin
                    if (pronto_rx && dado_recebido == CMD_BYTE) begin
                        r_estado <= MIN_D;
                    end
                end
                CONFIRMA: begin
`ifdef DECOD_PESO_CHECA_FAIXA_EN
                    if (w_min_sh > w_max_sh) begin
                        r_erro <= 1'b1;
                    end else begin
                        r_min   <= w_min_sh;
                        r_max   <= w_max_sh;
                        r_atual <= w_atual_sh;
                        r_novo  <= 1'b1;
                    end
`else
                    r_min   <= w_min_sh;
                    r_max   <= w_max_sh;
                    r_atual <= w_atual_sh;
                    r_novo  <= 1'b1;
`endif
                    r_estado <= ESPERA_CMD;
                end
                default: begin
                    if (pronto_rx) begin
                        if (eh_digito(dado_recebido)) begin
                            // Low nibble of '0'..'9' is already the digit value
                            case (r_estado)
                                MIN_D:   r_min_d   <= dado_recebido[3:0];
                                MIN_U:   r_min_u   <= dado_recebido[3:0];
                                MAX_D:   r_max_d   <= dado_recebido[3:0];
                                MAX_U:   r_max_u   <= dado_recebido[3:0];
                                ATUAL_D: r_atual_d <= dado_recebido[3:0];
                                ATUAL_U: r_atual_u <= dado_recebido[3:0];
                                default: ;
                            endcase
                            r_estado <= estado_t'(r_estado + 4'd1);
                        end else begin
                            r_erro    <= 1'b1;
                            r_estado  <= ESPERA_CMD;
                            r_min_d   <= '0;
                            r_min_u   <= '0;
                            r_max_d   <= '0;
                            r_max_u   <= '0;
                            r_atual_d <= '0;
                            r_atual_u <= '0;
                        end
                    end else if (w_estouro) begin
                        r_erro   <= 1'b1;
                        r_estado <= ESPERA_CMD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarme <= 1'b0;
        end else begin
            r_alarme <= (r_atual < r_min) || (r_atual > r_max);
        end
    end

    assign peso_min   = r_min;
    assign peso_max   = r_max;
    assign peso_atual = r_atual;
    assign novo_dado  = r_novo;
    assign erro       = r_erro;
    assign alarme     = r_alarme;
    assign db_estado  = r_estado;

endmodule

// File: doc/decodificador_comando_peso.md
# decodificador_comando_peso

Parses the byte stream delivered by the 8N1 serial receiver (115200 baud at 50 MHz, 434 clocks/bit) into three two-digit weight values: minimum, maximum and current. It sits between the UART receiver and the PWM/actuation logic of `circuito`. It latches each complete, valid frame and flags when the current weight falls outside [min, max].

## Interface
- `CMD_BYTE`, default 8'h30: frame start byte.
- `TIMEOUT_CICLOS`, default 86800: maximum idle clocks between bytes inside a frame (about 20 byte times).
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `dado_recebido`  in  8  received byte; valid only while `pronto_rx`=1.
- `pronto_rx`  in  1  one-cycle strobe from the receiver per byte.
- `peso_min`  out  7  latched minimum, 0..99, binary.
- `peso_max`  out  7  latched maximum, 0..99.
- `peso_atual`  out  7  latched current weight, 0..99.
- `novo_dado`  out  1  one-cycle pulse when outputs update.
- `alarme`  out  1  registered; 1 when `peso_atual` < `peso_min` or `peso_atual` > `peso_max`.
- `erro`  out  1  one-cycle pulse when a frame is aborted.
- `db_estado`  out  4  current state encoding, for debug.

## Operation
- Frame: `CMD_BYTE`, then six ASCII digits in order: min tens, min units, max tens, max units, atual tens, atual units.
- States, in order: ESPERA_CMD, MIN_D, MIN_U, MAX_D, MAX_U, ATUAL_D, ATUAL_U, CONFIRMA.
- ESPERA_CMD:
  - A strobe with `CMD_BYTE` moves to MIN_D.
  - Any other byte is ignored; no `erro`.
- Digit states:
  - Strobe with byte 0x30..0x39: store (byte − 0x30) in a shadow register and advance.
  - Any other byte: pulse `erro`, return to ESPERA_CMD, discard shadow values.
- Shadow conversion: value = tens×10 + units, computed in 7 bits; the maximum of 99 cannot overflow.
- CMD_BYTE (0x30) is also digit '0'. Inside a frame it is treated as a digit, so no restart-on-command.
- CONFIRMA: copy shadow to outputs, pulse `novo_dado`, return to ESPERA_CMD. Strobes arriving in this state are dropped.
- `alarme` is recomputed from the output registers every cycle (registered compare).
- Timeout:
  - A counter clears on every strobe and counts while the state is not ESPERA_CMD.
  - On reaching `TIMEOUT_CICLOS`: pulse `erro`, go to ESPERA_CMD.
  - Timeout and strobe in the same cycle: the strobe wins.
- Outputs never change on an aborted frame.

## Timing
- Reset values: `peso_min`=0, `peso_max`=0, `peso_atual`=0, `novo_dado`=0, `alarme`=0, `erro`=0, `db_estado`=ESPERA_CMD (0). Timeout counter is 0.
- Asynchronous reset mid-frame discards the partial frame immediately.
- Final-digit strobe at edge N → state CONFIRMA after edge N.
- Edge N+1: `peso_*` updated and `novo_dado`=1 for that cycle only; state returns to ESPERA_CMD.
- `alarme` reflects new values from edge N+2.
- `erro` asserts on the edge after the offending strobe or the timeout, for exactly one cycle.
- Back-to-back strobes on consecutive cycles are accepted in all digit states.

## Configuration
- `DECOD_PESO_CHECA_FAIXA_EN`:
  - Defined: in CONFIRMA, if shadow min > shadow max, outputs are not updated. `erro` pulses instead of `novo_dado`, same cycle.
  - Undefined: all syntactically valid frames latch as-is. An inverted range simply makes `alarme`=1 for every value.

## Structure
- Package `decodificador_pkg`:
  - state enum, 4-bit encoding;
  - ASCII constants `ASCII_0`=8'h30, `ASCII_9`=8'h39;
  - value width `LARGURA_PESO`=7.
- Sub-module `contador_timeout` (parameter `LIMITE`):
  - inputs: clear, enable;
  - output: `estouro` pulse.
- The FSM, shadow registers, BCD conversion and range compare stay in the top module.

## Test plan
- Valid frame: send 30 31 30 32 30 31 35 at 434 clk/bit.
  - Outputs min=10, max=20, atual=15.
  - `novo_dado` high one cycle; `alarme`=0.
- Out-of-range frame: send 30 31 30 32 30 32 35.
  - atual=25, `alarme`=1 two cycles after `novo_dado`.
- Invalid digit: send 30 31 41 …
  - `erro` pulses after 0x41; outputs hold previous values.
  - Next valid frame is accepted.
- Timeout: send 30 31 30, then idle for `TIMEOUT_CICLOS`+10.
  - `erro` pulses once; `db_estado`=0.
  - Next frame is accepted.
- Range check: send 30 33 30 32 30 31 35 (min 30 > max 20).
  - With the macro: `erro`, outputs unchanged.
  - Without the macro: min=30, max=20, `alarme`=1.
- Reset mid-frame: assert `reset` after the third byte.
  - All outputs 0, state 0.
  - A following full frame latches correctly.
